// File: rtl/sap_controller.sv
// rtl/sap_controller.sv - SAP-1 controller-sequencer: T1..T6 ring, HALT, control-word decode, carry/zero flags
module sap_controller (
  input  logic       CLK,
  input  logic       CLR_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       alu_c,
  input  logic       alu_z,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       lp,
  output logic       hlt,
  output logic       flag_c,
  output logic       flag_z,
  output logic [5:0] tstate
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_T6   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t state;
  state_t next_state;

  logic is_alu_op;
  assign is_alu_op = (opcode == OP_ADD) || (opcode == OP_SUB);

  // State register and flag latch; reset wins over run and HALT, run=0 freezes everything
  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      state  <= S_T1;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (run) begin
      state <= next_state;
      if (state == S_T6 && is_alu_op) begin
        flag_c <= alu_c;
        flag_z <= alu_z;
      end
    end
  end

  // Next-state ring, one-hot tstate view and Moore control-word decode
  always_comb begin
    next_state = state;
    tstate     = 6'b000000;
    hlt        = 1'b0;
    cp = 1'b0; ep = 1'b0; lm = 1'b0; ce = 1'b0; li = 1'b0; ei = 1'b0;
    la = 1'b0; ea = 1'b0; su = 1'b0; eu = 1'b0; lb = 1'b0; lo = 1'b0;
    lp = 1'b0;

    case (state)
      S_T1:    begin next_state = S_T2; tstate = 6'b000001; end
      S_T2:    begin next_state = S_T3; tstate = 6'b000010; end
      S_T3:    begin next_state = S_T4; tstate = 6'b000100; end
      S_T4:    begin
        next_state = (opcode == OP_HLT) ? S_HALT : S_T5;
        tstate     = 6'b001000;
      end
      S_T5:    begin next_state = S_T6; tstate = 6'b010000; end
      S_T6:    begin next_state = S_T1; tstate = 6'b100000; end
      S_HALT:  begin next_state = S_HALT; hlt = 1'b1; end
      default: next_state = S_T1;
    endcase

    if (run) begin
      case (state)
        S_T1: begin ep = 1'b1; lm = 1'b1; end
        S_T2: cp = 1'b1;
        S_T3: begin ce = 1'b1; li = 1'b1; end
        S_T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin ei = 1'b1; lm = 1'b1; end
            OP_OUT: begin ea = 1'b1; lo = 1'b1; end
            OP_JMP: begin ei = 1'b1; lp = 1'b1; end
            OP_JC:  begin ei = flag_c; lp = flag_c; end
            OP_JZ:  begin ei = flag_z; lp = flag_z; end
            default: ;
          endcase
        end
        S_T5: begin
          case (opcode)
            OP_LDA:         begin ce = 1'b1; la = 1'b1; end
            OP_ADD, OP_SUB: begin ce = 1'b1; lb = 1'b1; end
            default: ;
          endcase
        end
        S_T6: begin
          if (is_alu_op) begin
            eu = 1'b1;
            la = 1'b1;
            su = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_controller.sv
// tb/tb_sap_controller.sv - table-driven directed bench for sap_controller
module tb_sap_controller;

  // Strobe word layout: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo,lp}
  localparam logic [12:0] CP = 13'b1000000000000;
  localparam logic [12:0] EP = 13'b0100000000000;
  localparam logic [12:0] LM = 13'b0010000000000;
  localparam logic [12:0] CE = 13'b0001000000000;
  localparam logic [12:0] LI = 13'b0000100000000;
  localparam logic [12:0] EI = 13'b0000010000000;
  localparam logic [12:0] LA = 13'b0000001000000;
  localparam logic [12:0] EA = 13'b0000000100000;
  localparam logic [12:0] SU = 13'b0000000010000;
  localparam logic [12:0] EU = 13'b0000000001000;
  localparam logic [12:0] LB = 13'b0000000000100;
  localparam logic [12:0] LO = 13'b0000000000010;
  localparam logic [12:0] LP = 13'b0000000000001;
  localparam logic [12:0] NONE = 13'b0;

  localparam logic [5:0] T1 = 6'b000001, T2 = 6'b000010, T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000, T5 = 6'b010000, T6 = 6'b100000;

  typedef struct {
    logic        run;
    logic        clr_n;
    logic [3:0]  op;
    logic        c;
    logic        z;
    logic [5:0]  exp_ts;
    logic [12:0] exp_sw;
    logic        exp_hlt;
    logic        exp_fc;
    logic        exp_fz;
  } vec_t;

  logic       CLK = 1'b0;
  logic       CLR_n;
  logic       run;
  logic [3:0] opcode;
  logic       alu_c, alu_z;
  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, lp;
  logic hlt, flag_c, flag_z;
  logic [5:0] tstate;

  int n_pass = 0;
  int n_total = 0;
  vec_t vecs[$];

  sap_controller dut (
    .CLK(CLK), .CLR_n(CLR_n), .run(run), .opcode(opcode), .alu_c(alu_c), .alu_z(alu_z),
    .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la), .ea(ea),
    .su(su), .eu(eu), .lb(lb), .lo(lo), .lp(lp), .hlt(hlt),
    .flag_c(flag_c), .flag_z(flag_z), .tstate(tstate)
  );

  always #5 CLK = ~CLK;

  function automatic logic [12:0] strobes();
    return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, lp};
  endfunction

  task automatic chk(input string name, input int idx, input logic [12:0] act, input logic [12:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec=%0d actual=%b required=%b", name, idx, act, exp);
  endtask

  task automatic check_outputs(input int idx, input logic [5:0] ts, input logic [12:0] sw,
                               input logic h, input logic fc, input logic fz);
    chk("strobes", idx, strobes(), sw);
    chk("tstate", idx, {7'b0, tstate}, {7'b0, ts});
    chk("hlt_flags", idx, {10'b0, hlt, flag_c, flag_z}, {10'b0, h, fc, fz});
    chk("bus_onehot", idx, {12'b0, ($countones({ep, ce, ei, ea, eu}) <= 1)}, 13'b1);
  endtask

  task automatic add_vec(input logic r, input logic cl, input logic [3:0] op, input logic c,
                         input logic z, input logic [5:0] ts, input logic [12:0] sw,
                         input logic h, input logic fc, input logic fz);
    vec_t v;
    v.run = r; v.clr_n = cl; v.op = op; v.c = c; v.z = z;
    v.exp_ts = ts; v.exp_sw = sw; v.exp_hlt = h; v.exp_fc = fc; v.exp_fz = fz;
    vecs.push_back(v);
  endtask

  // Full six-cycle instruction; ALU inputs are inverted outside T6 so stray flag loads show up
  task automatic add_instr(input logic [3:0] op, input logic c6, input logic z6,
                           input logic [12:0] sw4, input logic [12:0] sw5, input logic [12:0] sw6,
                           input logic fc, input logic fz);
    add_vec(1, 1, op, ~c6, ~z6, T1, EP | LM, 0, fc, fz);
    add_vec(1, 1, op, ~c6, ~z6, T2, CP,      0, fc, fz);
    add_vec(1, 1, op, ~c6, ~z6, T3, CE | LI, 0, fc, fz);
    add_vec(1, 1, op, ~c6, ~z6, T4, sw4,     0, fc, fz);
    add_vec(1, 1, op, ~c6, ~z6, T5, sw5,     0, fc, fz);
    add_vec(1, 1, op,  c6,  z6, T6, sw6,     0, fc, fz);
  endtask

  initial begin
    add_instr(4'h1, 1, 0, EI | LM, CE | LB, EU | LA,      0, 0);
    add_instr(4'h2, 0, 1, EI | LM, CE | LB, EU | LA | SU, 1, 0);
    add_instr(4'h8, 1, 1, EI | LP, NONE, NONE,            0, 1);
    add_instr(4'h2, 1, 0, EI | LM, CE | LB, EU | LA | SU, 0, 1);
    add_instr(4'h8, 1, 1, NONE, NONE, NONE,               1, 0);
    add_instr(4'h2, 0, 0, EI | LM, CE | LB, EU | LA | SU, 1, 0);
    add_instr(4'h7, 1, 1, NONE, NONE, NONE,               0, 0);
    add_instr(4'h3, 1, 1, EI | LP, NONE, NONE,            0, 0);
    add_instr(4'h5, 1, 1, NONE, NONE, NONE,               0, 0);
    add_instr(4'h0, 1, 1, EI | LM, CE | LA, NONE,         0, 0);
    add_instr(4'h1, 1, 1, EI | LM, CE | LB, EU | LA,      0, 0);
    // SUB interrupted by reset in T5
    add_vec(1, 1, 4'h2, 0, 0, T1, EP | LM, 0, 1, 1);
    add_vec(1, 1, 4'h2, 0, 0, T2, CP,      0, 1, 1);
    add_vec(1, 1, 4'h2, 0, 0, T3, CE | LI, 0, 1, 1);
    add_vec(1, 1, 4'h2, 0, 0, T4, EI | LM, 0, 1, 1);
    add_vec(1, 0, 4'h2, 1, 1, T5, CE | LB, 0, 1, 1);
    // OUT with a 5-cycle run=0 freeze in T3
    add_vec(1, 1, 4'hE, 1, 1, T1, EP | LM, 0, 0, 0);
    add_vec(1, 1, 4'hE, 1, 1, T2, CP,      0, 0, 0);
    for (int i = 0; i < 5; i++) add_vec(0, 1, 4'hE, 1, 1, T3, NONE, 0, 0, 0);
    add_vec(1, 1, 4'hE, 1, 1, T3, CE | LI, 0, 0, 0);
    add_vec(1, 1, 4'hE, 1, 1, T4, EA | LO, 0, 0, 0);
    add_vec(1, 1, 4'hE, 1, 1, T5, NONE,    0, 0, 0);
    add_vec(1, 1, 4'hE, 1, 1, T6, NONE,    0, 0, 0);
    // HLT fetch and T4
    add_vec(1, 1, 4'hF, 1, 1, T1, EP | LM, 0, 0, 0);
    add_vec(1, 1, 4'hF, 1, 1, T2, CP,      0, 0, 0);
    add_vec(1, 1, 4'hF, 1, 1, T3, CE | LI, 0, 0, 0);
    add_vec(1, 1, 4'hF, 1, 1, T4, NONE,    0, 0, 0);

    CLR_n = 1'b0; run = 1'b1; opcode = 4'h0; alu_c = 1'b0; alu_z = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    CLR_n = 1'b1;
    #1;
    check_outputs(-1, T1, EP | LM, 0, 0, 0);

    foreach (vecs[i]) begin
      run = vecs[i].run; CLR_n = vecs[i].clr_n; opcode = vecs[i].op;
      alu_c = vecs[i].c; alu_z = vecs[i].z;
      #1;
      check_outputs(i, vecs[i].exp_ts, vecs[i].exp_sw, vecs[i].exp_hlt,
                    vecs[i].exp_fc, vecs[i].exp_fz);
      @(negedge CLK);
    end

    // HALT is absorbing for 20 cycles, even with the ALU toggling
    CLR_n = 1'b1; run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      opcode = 4'(i); alu_c = i[0]; alu_z = i[1];
      #1;
      check_outputs(1000 + i, 6'b000000, NONE, 1, 0, 0);
      @(negedge CLK);
    end

    // Reset out of HALT
    CLR_n = 1'b0; opcode = 4'hF;
    @(negedge CLK);
    CLR_n = 1'b1;
    #1;
    check_outputs(2000, T1, EP | LM, 0, 0, 0);
    @(negedge CLK);
    #1;
    check_outputs(2001, T2, CP, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
